// File: rtl/exe_bypass_unit_pkg.sv
// Shared pipeline definitions for the Execute bypass unit: forward-select codes,
// slot layouts for the E/M/WB reservation tracking, and the bubble constants.
package exe_bypass_unit_pkg;

  localparam int REG_W = 5;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_M  = 2'b01;
  localparam logic [1:0] FWD_WB = 2'b10;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic             we;
    logic             ld;
  } e_slot_t;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             we;
    logic             ld;
  } m_slot_t;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             we;
  } wb_slot_t;

  localparam e_slot_t  E_BUBBLE  = '{rs1: REG_ZERO, rs2: REG_ZERO, rd: REG_ZERO, we: 1'b0, ld: 1'b0};
  localparam m_slot_t  M_BUBBLE  = '{rd: REG_ZERO, we: 1'b0, ld: 1'b0};
  localparam wb_slot_t WB_BUBBLE = '{rd: REG_ZERO, we: 1'b0};

  // x0 is hard-wired zero, so a producer targeting it never matches a reader
  function automatic logic reg_hit(input logic [REG_W-1:0] rd, input logic [REG_W-1:0] src);
    return (rd != REG_ZERO) && (rd == src);
  endfunction

endpackage

// File: rtl/exe_bypass_unit_bypass_match.sv
// Single forwarding compare: does an in-flight non-load writer of rd supply src.
module bypass_match #(
  parameter int W = 5
) (
  input  logic         we_i,
  input  logic         ld_i,
  input  logic [W-1:0] rd_i,
  input  logic [W-1:0] src_i,
  output logic         hit_o
);

  assign hit_o = we_i & ~ld_i & (rd_i != {W{1'b0}}) & (rd_i == src_i);

endmodule

// File: rtl/exe_bypass_unit_chk.sv
// Invariant checker: a load in M must never be the producer of an operand in E.
module exe_bypass_unit_chk #(
  parameter int W = 5
) (
  input logic         clk,
  input logic         reset_E,
  input logic         m_we_i,
  input logic         m_ld_i,
  input logic [W-1:0] m_rd_i,
  input logic [W-1:0] e_rs1_i,
  input logic [W-1:0] e_rs2_i
);

  logic m_load_feeds_e_s;

  assign m_load_feeds_e_s = m_we_i & m_ld_i & (m_rd_i != {W{1'b0}}) &
                            ((m_rd_i == e_rs1_i) | (m_rd_i == e_rs2_i));

  a_no_load_fwd_from_m: assert property (@(posedge clk) disable iff (reset_E) !m_load_feeds_e_s);

endmodule

// File: rtl/exe_bypass_unit.sv
// Execute-side hazard unit: tracks E/M/WB destination reservations, selects operand
// forwarding for Execute, and inserts a single bubble on load-use.
module exe_bypass_unit
  import exe_bypass_unit_pkg::*;
#(
  parameter int REG_ADDR_W = REG_W,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset_E,
  input  logic                  flush_E,
  input  logic                  stall_E,
  input  logic [REG_ADDR_W-1:0] rs1_D,
  input  logic [REG_ADDR_W-1:0] rs2_D,
  input  logic [REG_ADDR_W-1:0] rd_D,
  input  logic                  reg_WE_D,
  input  logic                  mem_rd_D,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  stall_FD,
  output logic                  bubble_E,
  output logic [CNT_W-1:0]      stall_cycles
);

  e_slot_t          e_q,  e_d;
  m_slot_t          m_q,  m_d;
  wb_slot_t         wb_q, wb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic hit_m_a_s, hit_m_b_s, hit_wb_a_s, hit_wb_b_s;

  bypass_match #(.W(REG_W)) u_match_m_a (
    .we_i(m_q.we), .ld_i(m_q.ld), .rd_i(m_q.rd), .src_i(e_q.rs1), .hit_o(hit_m_a_s)
  );
  bypass_match #(.W(REG_W)) u_match_m_b (
    .we_i(m_q.we), .ld_i(m_q.ld), .rd_i(m_q.rd), .src_i(e_q.rs2), .hit_o(hit_m_b_s)
  );
  bypass_match #(.W(REG_W)) u_match_wb_a (
    .we_i(wb_q.we), .ld_i(1'b0), .rd_i(wb_q.rd), .src_i(e_q.rs1), .hit_o(hit_wb_a_s)
  );
  bypass_match #(.W(REG_W)) u_match_wb_b (
    .we_i(wb_q.we), .ld_i(1'b0), .rd_i(wb_q.rd), .src_i(e_q.rs2), .hit_o(hit_wb_b_s)
  );

  // Load-use detection against the instruction currently in Decode
  always_comb begin
    stall_FD = e_q.ld & e_q.we & (reg_hit(e_q.rd, rs1_D) | reg_hit(e_q.rd, rs2_D));
    bubble_E = stall_FD | flush_E;
  end

  // Operand source selection; M is younger than WB and wins
  always_comb begin
    if (hit_m_a_s) begin
      fwd_a_sel = FWD_M;
    end else if (hit_wb_a_s) begin
      fwd_a_sel = FWD_WB;
    end else begin
      fwd_a_sel = FWD_RF;
    end
    if (hit_m_b_s) begin
      fwd_b_sel = FWD_M;
    end else if (hit_wb_b_s) begin
      fwd_b_sel = FWD_WB;
    end else begin
      fwd_b_sel = FWD_RF;
    end
  end

  // Next-state for the reservation slots and the saturating stall counter
  always_comb begin
    e_d = e_q;
    if (stall_E) begin
      e_d = e_q;
    end else if (bubble_E) begin
      e_d = E_BUBBLE;
    end else begin
      e_d = '{rs1: rs1_D, rs2: rs2_D, rd: rd_D, we: reg_WE_D, ld: mem_rd_D};
    end

    if (stall_E) begin
      m_d = M_BUBBLE;
    end else begin
      m_d = '{rd: e_q.rd, we: e_q.we, ld: e_q.ld};
    end

    wb_d = '{rd: m_q.rd, we: m_q.we};

    if (stall_FD && !stall_E && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers; reset drops every in-flight reservation at once
  always_ff @(posedge clk or posedge reset_E) begin
    if (reset_E) begin
      e_q   <= E_BUBBLE;
      m_q   <= M_BUBBLE;
      wb_q  <= WB_BUBBLE;
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      e_q   <= e_d;
      m_q   <= m_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

  assign stall_cycles = cnt_q;

  exe_bypass_unit_chk #(.W(REG_W)) u_chk (
    .clk     (clk),
    .reset_E (reset_E),
    .m_we_i  (m_q.we),
    .m_ld_i  (m_q.ld),
    .m_rd_i  (m_q.rd),
    .e_rs1_i (e_q.rs1),
    .e_rs2_i (e_q.rs2)
  );

endmodule

// File: tb/tb_exe_bypass_unit.sv
// Self-checking bench for exe_bypass_unit: directed scenarios plus randomized traffic
// compared against an instruction-level pipeline model.
module tb_exe_bypass_unit;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk, reset_E, flush_E, stall_E;
  logic [4:0]       rs1_D, rs2_D, rd_D;
  logic             reg_WE_D, mem_rd_D;
  logic [1:0]       fwd_a_sel, fwd_b_sel;
  logic             stall_FD, bubble_E;
  logic [CNT_W-1:0] stall_cycles;

  int n_tests = 0;
  int n_fail  = 0;

  exe_bypass_unit #(.REG_ADDR_W(5), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_E(reset_E), .flush_E(flush_E), .stall_E(stall_E),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .rd_D(rd_D), .reg_WE_D(reg_WE_D), .mem_rd_D(mem_rd_D),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall_FD(stall_FD),
    .bubble_E(bubble_E), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction-level model: pipe[0]=Execute, pipe[1]=Memory, pipe[2]=Writeback
  typedef struct {
    int rs1;
    int rs2;
    int rd;
    bit we;
    bit ld;
  } ins_t;

  ins_t pipe[3];
  int   mcnt;

  function automatic ins_t nop();
    ins_t n;
    n.rs1 = 0; n.rs2 = 0; n.rd = 0; n.we = 1'b0; n.ld = 1'b0;
    return n;
  endfunction

  function automatic bit exp_stall();
    if (!(pipe[0].ld && pipe[0].we) || pipe[0].rd == 0) return 1'b0;
    return (pipe[0].rd == int'(rs1_D)) || (pipe[0].rd == int'(rs2_D));
  endfunction

  // Youngest in-flight producer supplies the value; a load in M cannot forward
  function automatic int exp_sel(int s);
    if (s == 0) return 0;
    if (pipe[1].we && !pipe[1].ld && pipe[1].rd == s) return 1;
    if (pipe[2].we && pipe[2].rd == s) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) pipe[k] = nop();
    mcnt = 0;
  endtask

  task automatic model_edge();
    bit   st;
    ins_t d;
    st = exp_stall();
    d.rs1 = rs1_D; d.rs2 = rs2_D; d.rd = rd_D; d.we = reg_WE_D; d.ld = mem_rd_D;
    if (st && !stall_E && mcnt < CNT_MAX) mcnt++;
    pipe[2] = pipe[1];
    pipe[1] = stall_E ? nop() : pipe[0];
    if (!stall_E) pipe[0] = (st || flush_E) ? nop() : d;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int a, int b, int d, bit we, bit ld);
    rs1_D = 5'(a); rs2_D = 5'(b); rd_D = 5'(d); reg_WE_D = we; mem_rd_D = ld;
    #1;
  endtask

  task automatic do_reset();
    reset_E = 1'b1;
    #2;
    reset_E = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    drive(0, 0, 0, 1'b0, 1'b0);
    n_tests++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin n_fail++; $display("FAIL reset_sel: got %b required 0000", {fwd_a_sel, fwd_b_sel}); end
    n_tests++; if ({stall_FD, bubble_E} !== 2'b00) begin n_fail++; $display("FAIL reset_stall: got %b required 00", {stall_FD, bubble_E}); end
    n_tests++; if (stall_cycles !== 4'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d required 0", stall_cycles); end
    // Build live state: counter at 1, load x7 in E, dependent in D
    drive(0, 0, 7, 1'b1, 1'b1); tick();
    drive(7, 0, 8, 1'b1, 1'b0); tick(); tick();
    drive(0, 0, 7, 1'b1, 1'b1); tick();
    drive(7, 1, 9, 1'b1, 1'b0);
    n_tests++; if (stall_FD !== 1'b1 || stall_cycles !== 4'd1) begin n_fail++; $display("FAIL reset_live: got stall=%b cnt=%0d required stall=1 cnt=1", stall_FD, stall_cycles); end
    #2 reset_E = 1'b1;
    #1;
    n_tests++; if ({fwd_a_sel, fwd_b_sel, stall_FD, bubble_E} !== 6'b0 || stall_cycles !== 4'd0) begin
      n_fail++; $display("FAIL reset_async: got sel=%b%b stall=%b bubble=%b cnt=%0d required all 0", fwd_a_sel, fwd_b_sel, stall_FD, bubble_E, stall_cycles);
    end
    #1 reset_E = 1'b0;
    model_reset();
  endtask

  task automatic test_alu_forward();
    do_reset();
    drive(0, 0, 5, 1'b1, 1'b0); tick();
    drive(5, 1, 6, 1'b1, 1'b0);
    n_tests++; if (stall_FD !== 1'b0) begin n_fail++; $display("FAIL alu_nostall: got %b required 0", stall_FD); end
    tick();
    drive(0, 0, 0, 1'b0, 1'b0);
    n_tests++; if (fwd_a_sel !== 2'b01 || fwd_b_sel !== 2'b00) begin n_fail++; $display("FAIL alu_fwd_m: got a=%b b=%b required a=01 b=00", fwd_a_sel, fwd_b_sel); end
    tick();
    n_tests++; if (fwd_a_sel !== 2'b00) begin n_fail++; $display("FAIL alu_after: got %b required 00", fwd_a_sel); end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(0, 0, 7, 1'b1, 1'b1); tick();
    drive(7, 7, 8, 1'b1, 1'b0);
    n_tests++; if (stall_FD !== 1'b1 || bubble_E !== 1'b1) begin n_fail++; $display("FAIL lu_stall: got stall=%b bubble=%b required 1 1", stall_FD, bubble_E); end
    tick();
    n_tests++; if (stall_FD !== 1'b0 || fwd_a_sel !== 2'b00) begin n_fail++; $display("FAIL lu_bubble: got stall=%b a=%b required 0 00", stall_FD, fwd_a_sel); end
    tick();
    drive(0, 0, 0, 1'b0, 1'b0);
    n_tests++; if (fwd_a_sel !== 2'b10 || fwd_b_sel !== 2'b10) begin n_fail++; $display("FAIL lu_fwd_wb: got a=%b b=%b required 10 10", fwd_a_sel, fwd_b_sel); end
    n_tests++; if (stall_cycles !== 4'd1) begin n_fail++; $display("FAIL lu_cnt: got %0d required 1", stall_cycles); end
  endtask

  task automatic test_priority_x0();
    do_reset();
    drive(0, 0, 9, 1'b1, 1'b0); tick();
    drive(9, 0, 9, 1'b1, 1'b0); tick();
    drive(9, 9, 10, 1'b1, 1'b0); tick();
    n_tests++; if (fwd_a_sel !== 2'b01 || fwd_b_sel !== 2'b01) begin n_fail++; $display("FAIL prio_m_wins: got a=%b b=%b required 01 01", fwd_a_sel, fwd_b_sel); end
    drive(0, 0, 0, 1'b1, 1'b0); tick();
    drive(0, 0, 0, 1'b1, 1'b1); tick();
    drive(0, 0, 11, 1'b1, 1'b0);
    n_tests++; if (stall_FD !== 1'b0) begin n_fail++; $display("FAIL x0_nostall: got %b required 0", stall_FD); end
    tick();
    n_tests++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin n_fail++; $display("FAIL x0_sel: got %b required 0000", {fwd_a_sel, fwd_b_sel}); end
  endtask

  task automatic test_flush_stall();
    do_reset();
    drive(0, 0, 3, 1'b1, 1'b1); tick();
    flush_E = 1'b1;
    drive(3, 0, 4, 1'b1, 1'b0);
    n_tests++; if (stall_FD !== 1'b1 || bubble_E !== 1'b1) begin n_fail++; $display("FAIL flush_lu: got stall=%b bubble=%b required 1 1", stall_FD, bubble_E); end
    tick();
    flush_E = 1'b0;
    #1;
    n_tests++; if (stall_FD !== 1'b0 || stall_cycles !== 4'd1) begin n_fail++; $display("FAIL flush_e_bubble: got stall=%b cnt=%0d required 0 1", stall_FD, stall_cycles); end
    tick();
    n_tests++; if (fwd_a_sel !== 2'b10) begin n_fail++; $display("FAIL flush_dep_wb: got %b required 10", fwd_a_sel); end
    // Hold E for two cycles: the WB producer drains and M fills with bubbles
    stall_E = 1'b1;
    drive(0, 0, 12, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      tick();
      n_tests++; if (fwd_a_sel !== 2'(exp_sel(pipe[0].rs1)) || fwd_a_sel !== 2'b00) begin n_fail++; $display("FAIL stallE_hold%0d: got %b required 00", k, fwd_a_sel); end
    end
    stall_E = 1'b0;
    drive(3, 0, 13, 1'b1, 1'b0); tick();
    n_tests++; if (pipe[0].rs1 != 3 || fwd_a_sel !== 2'b00 || stall_cycles !== 4'd1) begin n_fail++; $display("FAIL stallE_after: got a=%b cnt=%0d required 00 1", fwd_a_sel, stall_cycles); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < (1 << CNT_W) + 3; k++) begin
      drive(0, 0, 1, 1'b1, 1'b1); tick();
      drive(1, 2, 2, 1'b1, 1'b0); tick(); tick();
    end
    n_tests++; if (stall_cycles !== 4'hF || mcnt != CNT_MAX) begin n_fail++; $display("FAIL sat_cnt: got %0d required 15", stall_cycles); end
  endtask

  task automatic test_random();
    logic [9:0] got, exp;
    bit         ld;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (c % 97 == 96) do_reset();
      ld      = ($urandom_range(0, 2) == 0);
      flush_E = ($urandom_range(0, 9) == 0);
      stall_E = ($urandom_range(0, 9) == 0);
      drive($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), ld ? 1'b1 : 1'($urandom_range(0, 1)), ld);
      exp = {2'(exp_sel(pipe[0].rs1)), 2'(exp_sel(pipe[0].rs2)), exp_stall(), exp_stall() | flush_E, 4'(mcnt)};
      got = {fwd_a_sel, fwd_b_sel, stall_FD, bubble_E, stall_cycles};
      n_tests++; if (got !== exp) begin n_fail++; $display("FAIL rand_c%0d: got %b required %b", c, got, exp); end
      tick();
    end
    flush_E = 1'b0;
    stall_E = 1'b0;
  endtask

  initial begin
    reset_E = 1'b1; flush_E = 1'b0; stall_E = 1'b0;
    rs1_D = 5'd0; rs2_D = 5'd0; rd_D = 5'd0; reg_WE_D = 1'b0; mem_rd_D = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_alu_forward();
    test_load_use();
    test_priority_x0();
    test_flush_stall();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
